// File: rtl/multi_one_shot_if.sv
// Bundled trigger configuration and pulse outputs for multi_one_shot.
// The master drives triggers and configuration; the slave is the one-shot bank.
interface multi_one_shot_if #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DROP_W = 8
);
  logic [NCH-1:0]        trig;
  logic [NCH*CNT_W-1:0]  len;
  logic [NCH*CNT_W-1:0]  holdoff;
  logic [NCH-1:0]        retrig;
  logic [2*NCH-1:0]      edge_sel;
  logic                  clr_drop;
  logic [NCH-1:0]        y;
  logic [NCH-1:0]        done;
  logic [NCH*DROP_W-1:0] drop_cnt;
  logic                  busy;

  modport master (
    output trig, len, holdoff, retrig, edge_sel, clr_drop,
    input  y, done, drop_cnt, busy
  );

  modport slave (
    input  trig, len, holdoff, retrig, edge_sel, clr_drop,
    output y, done, drop_cnt, busy
  );
endinterface

// File: rtl/multi_one_shot.sv
// Bank of NCH independent edge-triggered one-shots with optional retrigger,
// post-pulse holdoff and saturating per-channel dropped-edge counters.
module multi_one_shot #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DROP_W = 8
) (
  input logic             clk,
  input logic             rst,
  multi_one_shot_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StActive, StHoldoff} state_e;

  logic [NCH-1:0]        y_w;
  logic [NCH-1:0]        done_w;
  logic [NCH-1:0]        act_w;
  logic [NCH*DROP_W-1:0] drop_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e            state_q, state_d;
    logic              trig_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  ch_len, ch_hold;
    logic [1:0]        ch_sel;
    logic              y_q, y_d, done_q, done_d;
    logic              edge_det, drop;
    logic [DROP_W-1:0] drop_q, drop_d;

    assign ch_len  = bus.len[i*CNT_W +: CNT_W];
    assign ch_hold = bus.holdoff[i*CNT_W +: CNT_W];
    assign ch_sel  = bus.edge_sel[2*i +: 2];

    always_comb begin
      edge_det = 1'b0;
      unique case (ch_sel)
        2'b00:   edge_det = bus.trig[i] & ~trig_q;
        2'b01:   edge_det = ~bus.trig[i] & trig_q;
        2'b10:   edge_det = bus.trig[i] ^ trig_q;
        default: edge_det = 1'b0;
      endcase
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hcnt_d  = hcnt_q;
      y_d     = y_q;
      done_d  = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (edge_det && ch_len != '0) begin
            cnt_d   = ch_len;
            y_d     = 1'b1;
            state_d = StActive;
          end
        end
        StActive: begin
          if (edge_det && bus.retrig[i] && ch_len != '0) begin
            cnt_d = ch_len;
          end else begin
            // A zero-length retrigger is ignored, not dropped.
            drop = edge_det & ~bus.retrig[i];
            if (cnt_q > CNT_W'(1)) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              cnt_d  = '0;
              y_d    = 1'b0;
              done_d = 1'b1;
              if (ch_hold != '0) begin
                hcnt_d  = ch_hold;
                state_d = StHoldoff;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        StHoldoff: begin
          drop = edge_det;
          if (hcnt_q == CNT_W'(1)) begin
            hcnt_d  = '0;
            state_d = StIdle;
          end else begin
            hcnt_d = hcnt_q - CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_comb begin
      drop_d = drop_q;
      if (bus.clr_drop) begin
        drop_d = '0;
      end else if (drop && drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= StIdle;
        trig_q  <= 1'b0;
        cnt_q   <= '0;
        hcnt_q  <= '0;
        y_q     <= 1'b0;
        done_q  <= 1'b0;
        drop_q  <= '0;
      end else begin
        state_q <= state_d;
        trig_q  <= bus.trig[i];
        cnt_q   <= cnt_d;
        hcnt_q  <= hcnt_d;
        y_q     <= y_d;
        done_q  <= done_d;
        drop_q  <= drop_d;
      end
    end

    assign y_w[i]                  = y_q;
    assign done_w[i]               = done_q;
    assign act_w[i]                = (state_q != StIdle);
    assign drop_w[i*DROP_W +: DROP_W] = drop_q;
  end

  assign bus.y        = y_w;
  assign bus.done     = done_w;
  assign bus.drop_cnt = drop_w;
  assign bus.busy     = |act_w;
endmodule

// File: tb/tb_multi_one_shot.sv
// Scenario bench for multi_one_shot: expected per-cycle outputs are queued
// before stimulus and popped as each clock edge is observed.
module tb_multi_one_shot;
  localparam int unsigned NCH = 4, CNT_W = 8, DROP_W = 8;

  typedef struct {
    logic y;
    logic done;
    logic busy;
  } exp_t;

  logic clk, rst;
  int   checks, failures;
  exp_t sbq[$];

  multi_one_shot_if #(.NCH(NCH), .CNT_W(CNT_W), .DROP_W(DROP_W)) bus ();

  multi_one_shot #(.NCH(NCH), .CNT_W(CNT_W), .DROP_W(DROP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.trig = '0; bus.len = '0; bus.holdoff = '0; bus.retrig = '0;
    bus.edge_sel = '0; bus.clr_drop = 1'b0;
    idle(2);
    checks += 4;
    if (bus.y !== 4'h0) begin failures++; $display("FAIL reset_y got %h want 0", bus.y); end
    if (bus.done !== 4'h0) begin failures++; $display("FAIL reset_done got %h want 0", bus.done); end
    if (bus.drop_cnt !== 32'h0) begin
      failures++; $display("FAIL reset_drop got %h want 0", bus.drop_cnt);
    end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    exp_t e;
    bus.len[7:0] = 8'd6; bus.holdoff[7:0] = 8'd0; bus.retrig[0] = 1'b0;
    bus.edge_sel[1:0] = 2'b00;
    for (int k = 1; k <= 9; k++) sbq.push_back('{y: k <= 6, done: k == 7, busy: k <= 6});
    for (int k = 1; k <= 9; k++) begin
      bus.trig[0] = (k == 1);
      tick();
      e = sbq.pop_front();
      checks += 3;
      if (bus.y[0] !== e.y) begin failures++; $display("FAIL single_y k=%0d got %b want %b", k, bus.y[0], e.y); end
      if (bus.done[0] !== e.done) begin
        failures++; $display("FAIL single_done k=%0d got %b want %b", k, bus.done[0], e.done);
      end
      if (bus.busy !== e.busy) begin
        failures++; $display("FAIL single_busy k=%0d got %b want %b", k, bus.busy, e.busy);
      end
    end
  endtask

  task automatic test_nonretrig();
    exp_t e;
    for (int k = 1; k <= 9; k++) sbq.push_back('{y: k <= 6, done: k == 7, busy: k <= 6});
    for (int k = 1; k <= 9; k++) begin
      bus.trig[0] = (k == 1 || k == 4 || k == 7);
      tick();
      e = sbq.pop_front();
      checks += 2;
      if (bus.y[0] !== e.y) begin failures++; $display("FAIL nonretrig_y k=%0d got %b want %b", k, bus.y[0], e.y); end
      if (bus.done[0] !== e.done) begin
        failures++; $display("FAIL nonretrig_done k=%0d got %b want %b", k, bus.done[0], e.done);
      end
    end
    checks++;
    if (bus.drop_cnt[7:0] !== 8'd2) begin
      failures++; $display("FAIL nonretrig_drop got %0d want 2", bus.drop_cnt[7:0]);
    end
    bus.clr_drop = 1'b1;
    tick();
    bus.clr_drop = 1'b0;
    checks++;
    if (bus.drop_cnt[7:0] !== 8'd0) begin
      failures++; $display("FAIL clr_drop got %0d want 0", bus.drop_cnt[7:0]);
    end
  endtask

  task automatic test_retrig();
    exp_t e;
    bus.len[15:8] = 8'd6; bus.holdoff[15:8] = 8'd0; bus.retrig[1] = 1'b1;
    bus.edge_sel[3:2] = 2'b00;
    for (int k = 1; k <= 14; k++) sbq.push_back('{y: k <= 12, done: k == 13, busy: k <= 12});
    for (int k = 1; k <= 14; k++) begin
      bus.trig[1] = (k == 1 || k == 4 || k == 7);
      tick();
      e = sbq.pop_front();
      checks += 3;
      if (bus.y[1] !== e.y) begin failures++; $display("FAIL retrig_y k=%0d got %b want %b", k, bus.y[1], e.y); end
      if (bus.done[1] !== e.done) begin
        failures++; $display("FAIL retrig_done k=%0d got %b want %b", k, bus.done[1], e.done);
      end
      if (bus.busy !== e.busy) begin
        failures++; $display("FAIL retrig_busy k=%0d got %b want %b", k, bus.busy, e.busy);
      end
    end
    checks++;
    if (bus.drop_cnt[15:8] !== 8'd0) begin
      failures++; $display("FAIL retrig_drop got %0d want 0", bus.drop_cnt[15:8]);
    end
  endtask

  task automatic test_holdoff();
    exp_t e;
    bus.len[23:16] = 8'd4; bus.holdoff[23:16] = 8'd5; bus.retrig[2] = 1'b0;
    bus.edge_sel[5:4] = 2'b10;
    // Edges land on odd cycles; holdoff covers cycles 6..10, next accept at 11.
    for (int k = 1; k <= 16; k++)
      sbq.push_back('{y: (k <= 4) || (k >= 11 && k <= 14), done: k == 5 || k == 15,
                      busy: k != 10});
    for (int k = 1; k <= 16; k++) begin
      bus.trig[2] = (k >= 14) ? 1'b1 : (((k - 1) / 2) % 2 == 0);
      tick();
      e = sbq.pop_front();
      checks += 3;
      if (bus.y[2] !== e.y) begin failures++; $display("FAIL holdoff_y k=%0d got %b want %b", k, bus.y[2], e.y); end
      if (bus.done[2] !== e.done) begin
        failures++; $display("FAIL holdoff_done k=%0d got %b want %b", k, bus.done[2], e.done);
      end
      if (bus.busy !== e.busy) begin
        failures++; $display("FAIL holdoff_busy k=%0d got %b want %b", k, bus.busy, e.busy);
      end
    end
    checks++;
    if (bus.drop_cnt[23:16] !== 8'd5) begin
      failures++; $display("FAIL holdoff_drop got %0d want 5", bus.drop_cnt[23:16]);
    end
    idle(8);
  endtask

  task automatic test_len0_disabled_sat();
    exp_t e;
    bus.len[31:24] = 8'd0; bus.holdoff[31:24] = 8'd0; bus.retrig[3] = 1'b0;
    bus.edge_sel[7:6] = 2'b00;
    for (int k = 1; k <= 8; k++) sbq.push_back('{y: 1'b0, done: 1'b0, busy: 1'b0});
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) begin
        bus.edge_sel[7:6] = 2'b11;
        bus.len[31:24] = 8'd5;
      end
      bus.trig[3] = (k == 1 || k == 5);
      tick();
      e = sbq.pop_front();
      checks += 2;
      if (bus.y[3] !== e.y) begin failures++; $display("FAIL len0_dis_y k=%0d got %b want %b", k, bus.y[3], e.y); end
      if (bus.busy !== e.busy) begin
        failures++; $display("FAIL len0_dis_busy k=%0d got %b want %b", k, bus.busy, e.busy);
      end
    end
    checks++;
    if (bus.drop_cnt[31:24] !== 8'd0) begin
      failures++; $display("FAIL len0_dis_drop got %0d want 0", bus.drop_cnt[31:24]);
    end
    bus.len[31:24] = 8'd200;
    bus.edge_sel[7:6] = 2'b10;
    for (int k = 1; k <= 320; k++) begin
      bus.trig[3] = k[0];
      tick();
    end
    checks++;
    if (bus.drop_cnt[31:24] !== 8'd255) begin
      failures++; $display("FAIL sat_drop got %0d want 255", bus.drop_cnt[31:24]);
    end
    idle(100);
    bus.edge_sel[7:6] = 2'b11;
  endtask

  task automatic test_reset_mid_pulse();
    exp_t e;
    bus.len[7:0] = 8'd10; bus.holdoff[7:0] = 8'd0; bus.retrig[0] = 1'b0;
    bus.len[15:8] = 8'd20; bus.retrig[1] = 1'b0;
    bus.trig[0] = 1'b1; bus.trig[1] = 1'b1;
    tick();
    bus.trig[1] = 1'b0;
    idle(2);
    checks++;
    if (bus.y[1:0] !== 2'b11) begin failures++; $display("FAIL pre_rst_y got %b want 11", bus.y[1:0]); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (bus.y !== 4'h0) begin failures++; $display("FAIL rst_async_y got %h want 0", bus.y); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got %b want 0", bus.busy); end
    if (bus.done !== 4'h0) begin failures++; $display("FAIL rst_async_done got %h want 0", bus.done); end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) sbq.push_back('{y: k <= 10, done: k == 11, busy: k <= 10});
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = sbq.pop_front();
      checks += 3;
      if (bus.y[0] !== e.y) begin failures++; $display("FAIL post_rst_y k=%0d got %b want %b", k, bus.y[0], e.y); end
      if (bus.done[0] !== e.done) begin
        failures++; $display("FAIL post_rst_done k=%0d got %b want %b", k, bus.done[0], e.done);
      end
      if (bus.busy !== e.busy) begin
        failures++; $display("FAIL post_rst_busy k=%0d got %b want %b", k, bus.busy, e.busy);
      end
    end
    bus.trig[0] = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_nonretrig();
    test_retrig();
    test_holdoff();
    test_len0_disabled_sat();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
